// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side bundle: serial line and frame config in, word and status out.
// master drives the line and reads results; slave is the receiver.
interface uart_rx_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
);
   logic                  rx_in;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [PRESC_W-1:0]    prescale;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  rx_busy;

   modport master (
      output rx_in,
      output PAR_EN,
      output PAR_TYP,
      output prescale,
      input  p_data,
      input  data_valid,
      input  par_err,
      input  stp_err,
      input  rx_busy
   );

   modport slave (
      input  rx_in,
      input  PAR_EN,
      input  PAR_TYP,
      input  prescale,
      output p_data,
      output data_valid,
      output par_err,
      output stp_err,
      output rx_busy
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled, majority-of-3 bit decision, optional parity,
// one stop bit; reports good words or parity/stop errors as 1-cycle pulses.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_rx_ctrl_if.slave bus
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e                state_q;
   state_e                state_d;
   logic                  rx_meta_q;
   logic                  rx_s_q;
   logic [PRESC_W-1:0]    edge_q;
   logic [PRESC_W-1:0]    edge_d;
   logic [BW-1:0]         bit_q;
   logic [BW-1:0]         bit_d;
   logic [PRESC_W-1:0]    presc_q;
   logic [PRESC_W-1:0]    presc_d;
   logic                  par_en_q;
   logic                  par_en_d;
   logic                  par_typ_q;
   logic                  par_typ_d;
   logic                  smp0_q;
   logic                  smp0_d;
   logic                  smp1_q;
   logic                  smp1_d;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_d;
   logic                  par_bad_q;
   logic                  par_bad_d;
   logic [DATA_WIDTH-1:0] p_data_q;
   logic [DATA_WIDTH-1:0] p_data_d;
   logic                  valid_q;
   logic                  valid_d;
   logic                  par_err_q;
   logic                  par_err_d;
   logic                  stp_err_q;
   logic                  stp_err_d;

   logic                  rx_s;
   logic [PRESC_W-1:0]    half;
   logic                  at_s0;
   logic                  at_s1;
   logic                  at_dec;
   logic                  at_end;
   logic                  bit_last;
   logic                  maj;
   logic                  par_calc;

   assign rx_s     = rx_s_q;
   assign half     = presc_q >> 1;
   assign at_s0    = (edge_q == half - PRESC_W'(1));
   assign at_s1    = (edge_q == half);
   assign at_dec   = (edge_q == half + PRESC_W'(1));
   assign at_end   = (edge_q == presc_q - PRESC_W'(1));
   assign bit_last = (bit_q == BW'(DATA_WIDTH - 1));
   // third sample is the live one, so the decision is ready at half+1
   assign maj      = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
   assign par_calc = (^shift_q) ^ par_typ_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= bus.rx_in;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         edge_q    <= '0;
         bit_q     <= '0;
         presc_q   <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         smp0_q    <= 1'b0;
         smp1_q    <= 1'b0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         edge_q    <= edge_d;
         bit_q     <= bit_d;
         presc_q   <= presc_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         smp0_q    <= smp0_d;
         smp1_q    <= smp1_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_data_q  <= '0;
         valid_q   <= 1'b0;
         par_err_q <= 1'b0;
         stp_err_q <= 1'b0;
      end else begin
         p_data_q  <= p_data_d;
         valid_q   <= valid_d;
         par_err_q <= par_err_d;
         stp_err_q <= stp_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      edge_d    = edge_q;
      bit_d     = bit_q;
      presc_d   = presc_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      smp0_d    = smp0_q;
      smp1_d    = smp1_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      p_data_d  = p_data_q;
      valid_d   = 1'b0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;

      if (state_q != S_IDLE) begin
         edge_d = at_end ? '0 : edge_q + PRESC_W'(1);
         if (at_s0) smp0_d = rx_s;
         if (at_s1) smp1_d = rx_s;
      end

      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d   = S_START;
               edge_d    = '0;
               bit_d     = '0;
               presc_d   = bus.prescale;
               par_en_d  = bus.PAR_EN;
               par_typ_d = bus.PAR_TYP;
               par_bad_d = 1'b0;
            end
         end
         S_START: begin
            if (at_dec && maj) begin
               state_d = S_IDLE;
               edge_d  = '0;
            end else if (at_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (at_dec) shift_d[bit_q] = maj;
            if (at_end) begin
               if (bit_last) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (at_dec && (par_calc != maj)) par_bad_d = 1'b1;
            if (at_end) state_d = S_STOP;
         end
         S_STOP: begin
            // leave at mid-stop so a back-to-back start edge is not missed
            if (at_dec) begin
               state_d   = S_IDLE;
               edge_d    = '0;
               stp_err_d = ~maj;
               par_err_d = par_bad_q;
               if (maj && !par_bad_q) begin
                  valid_d  = 1'b1;
                  p_data_d = shift_q;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            edge_d  = '0;
         end
      endcase
   end

   assign bus.p_data     = p_data_q;
   assign bus.data_valid = valid_q;
   assign bus.par_err    = par_err_q;
   assign bus.stp_err    = stp_err_q;
   assign bus.rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: fixed frame table, corner sequences and
// random frames checked against a frame-level outcome model.
module tb_uart_rx_ctrl;

   localparam int DW = 8;
   localparam int PW = 6;

   typedef struct {
      int       presc;
      bit       pen;
      bit       ptyp;
      bit [7:0] data;
      bit       pbad;
      bit       stop;
      int       ev;
      int       epe;
      int       ese;
      bit [7:0] epd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_ctrl_if #(.DATA_WIDTH(DW), .PRESC_W(PW)) bus ();

   uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int       total = 0;
   int       bad = 0;
   int       n_dv = 0;
   int       n_pe = 0;
   int       n_se = 0;
   int       n_busy = 0;
   bit [7:0] vq[$];
   bit [7:0] mdl_pdata;
   vec_t     vecs[8];

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.data_valid) begin
            n_dv++;
            vq.push_back(bus.p_data);
         end
         if (bus.par_err) n_pe++;
         if (bus.stp_err) n_se++;
         if (bus.rx_busy) n_busy++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      n_dv = 0;
      n_pe = 0;
      n_se = 0;
      n_busy = 0;
      vq.delete();
   endtask

   task automatic drive_bit(input bit b, input int n);
      bus.rx_in = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int presc, input bit pen, input bit ptyp,
                             input bit [7:0] data, input bit pbad,
                             input bit stop, input bit scramble);
      bus.prescale = PW'(presc);
      bus.PAR_EN   = pen;
      bus.PAR_TYP  = ptyp;
      drive_bit(1'b0, presc);
      for (int i = 0; i < DW; i++) begin
         if (scramble) begin
            bus.prescale = PW'($urandom_range(0, 63));
            bus.PAR_EN   = 1'($urandom_range(0, 1));
            bus.PAR_TYP  = 1'($urandom_range(0, 1));
         end
         drive_bit(data[i], presc);
      end
      bus.prescale = PW'(presc);
      bus.PAR_EN   = pen;
      bus.PAR_TYP  = ptyp;
      if (pen) drive_bit((^data) ^ ptyp ^ pbad, presc);
      drive_bit(stop, presc);
      bus.rx_in = 1'b1;
   endtask

   task automatic check_frame(input string tag, input int ev, input int epe,
                              input int ese, input bit [7:0] epd,
                              input int presc);
      repeat (2 * presc + 4) @(negedge clk);
      check({tag, "_dv"}, n_dv, ev);
      check({tag, "_pe"}, n_pe, epe);
      check({tag, "_se"}, n_se, ese);
      check({tag, "_pdata"}, int'(bus.p_data), int'(epd));
      check({tag, "_busy"}, int'(bus.rx_busy), 0);
   endtask

   initial begin
      bit       pen;
      bit       ptyp;
      bit       pbad;
      bit       stop;
      bit [7:0] data;
      int       presc;
      int       ev;
      int       epe;
      int       ese;

      vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
      vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
      vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 1, 0, 8'h3C};
      vecs[3] = '{16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 0, 0, 1, 8'h3C};
      vecs[4] = '{16, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1, 0, 0, 8'h12};
      vecs[5] = '{16, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 0, 1, 1, 8'h12};
      vecs[6] = '{32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1, 0, 0, 8'h01};
      vecs[7] = '{8,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};

      bus.rx_in    = 1'b1;
      bus.PAR_EN   = 1'b0;
      bus.PAR_TYP  = 1'b0;
      bus.prescale = PW'(16);
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pdata", int'(bus.p_data), 0);
      check("rst_dv", int'(bus.data_valid), 0);
      check("rst_pe", int'(bus.par_err), 0);
      check("rst_se", int'(bus.stp_err), 0);
      check("rst_busy", int'(bus.rx_busy), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      foreach (vecs[i]) begin
         clear_counts();
         send_frame(vecs[i].presc, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                    vecs[i].pbad, vecs[i].stop, 1'b0);
         check_frame($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epe,
                     vecs[i].ese, vecs[i].epd, vecs[i].presc);
      end

      // short low glitch must be rejected within one bit time
      bus.prescale = PW'(16);
      clear_counts();
      drive_bit(1'b0, 3);
      drive_bit(1'b1, 40);
      check("glitch_busy_seen", int'(n_busy > 0), 1);
      check("glitch_busy_len", int'(n_busy <= 16), 1);
      check("glitch_dv", n_dv, 0);
      check("glitch_pe", n_pe, 0);
      check("glitch_se", n_se, 0);
      check("glitch_busy_end", int'(bus.rx_busy), 0);

      // back-to-back frames, no idle between stop and next start
      clear_counts();
      send_frame(32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      send_frame(32, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
      repeat (70) @(negedge clk);
      check("b2b_dv", n_dv, 2);
      check("b2b_err", n_pe + n_se, 0);
      check("b2b_first", (vq.size() > 0) ? int'(vq[0]) : -1, 8'h01);
      check("b2b_second", (vq.size() > 1) ? int'(vq[1]) : -1, 8'hFF);

      // reset in the middle of data bit 4
      bus.prescale = PW'(16);
      bus.PAR_EN   = 1'b0;
      drive_bit(1'b0, 16);
      data = 8'h5A;
      for (int i = 0; i < 4; i++) drive_bit(data[i], 16);
      drive_bit(data[4], 8);
      check("pre_rst_busy", int'(bus.rx_busy), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_pdata", int'(bus.p_data), 0);
      check("mid_rst_busy", int'(bus.rx_busy), 0);
      check("mid_rst_flags",
            int'({bus.data_valid, bus.par_err, bus.stp_err}), 0);
      bus.rx_in = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      clear_counts();
      send_frame(16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
      check_frame("post_rst", 1, 0, 0, 8'h81, 16);
      mdl_pdata = 8'h81;

      for (int i = 0; i < 30; i++) begin
         presc = 8 << $urandom_range(0, 2);
         pen   = 1'($urandom_range(0, 1));
         ptyp  = 1'($urandom_range(0, 1));
         data  = 8'($urandom);
         pbad  = ($urandom_range(0, 4) == 0);
         stop  = ($urandom_range(0, 5) != 0);
         ese   = stop ? 0 : 1;
         epe   = (pen && pbad) ? 1 : 0;
         ev    = (ese == 0 && epe == 0) ? 1 : 0;
         if (ev == 1) mdl_pdata = data;
         clear_counts();
         send_frame(presc, pen, ptyp, data, pbad, stop, 1'b1);
         check_frame($sformatf("rnd%0d", i), ev, epe, ese, mdl_pdata, presc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
